// File: rtl/croc_field_if.sv
// Bus between the game top and the croc field: frog position and control in,
// lane positions, directions, level and event pulses out.
interface croc_field_if #(
    parameter int N_LANES = 3
);
    logic                  enable;
    logic [9:0]            frog_x;
    logic [9:0]            frog_y;
    logic                  win;
    logic [10*N_LANES-1:0] croc_y;
    logic [N_LANES-1:0]    croc_dir;
    logic [3:0]            level;
    logic                  tick;
    logic                  die;

    modport master (
        output enable, frog_x, frog_y, win,
        input  croc_y, croc_dir, level, tick, die
    );

    modport slave (
        input  enable, frog_x, frog_y, win,
        output croc_y, croc_dir, level, tick, die
    );
endinterface

// File: rtl/croc_field.sv
// Croc field: N_LANES vertically moving obstacle lanes driven by a tick
// prescaler, with level-scaled speed, bounce/wrap motion, bounding-box
// frog collision and a freeze period after each death.
module croc_field #(
    parameter int N_LANES    = 3,
    parameter int TICK_DIV   = 262144,
    parameter int Y_MIN      = 0,
    parameter int Y_MAX      = 479,
    parameter int CROC_W     = 20,
    parameter int CROC_H     = 40,
    parameter int FROG_W     = 16,
    parameter int FROG_H     = 16,
    parameter int LANE_X0    = 300,
    parameter int LANE_PITCH = 150,
    parameter int INIT_Y0    = 108,
    parameter int INIT_STEP  = 100,
    parameter int BASE_SPEED = 1,
    parameter int MAX_LEVEL  = 7,
    parameter int HOLD_TICKS = 2,
    parameter int WRAP_MODE  = 0
) (
    input  logic        clk,
    input  logic        reset,
    croc_field_if.slave bus
);
    localparam int          PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [10:0] LIM  = 11'(Y_MAX - CROC_H);
    localparam logic [10:0] YMIN = 11'(Y_MIN);

    typedef enum logic {RUN, HOLD} state_t;

    typedef struct packed {
        logic [9:0] y;
        logic       dir;
    } lane_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q;
    logic [7:0]    hold_q, hold_d;
    logic [3:0]    level_q, level_d;
    logic          die_q, die_d;
    logic          do_reload, do_move;
    logic          tick_w;
    logic          hit_any;
    logic [9:0]    y_q [N_LANES];
    logic [N_LANES-1:0] dir_q;
    lane_t         nxt [N_LANES];

    // Lane speed grows with lane index and level, capped at the 4-bit maximum.
    function automatic logic [3:0] sat_speed(input int lane, input logic [3:0] lvl);
        int s;
        s = BASE_SPEED + lane + int'(lvl);
        return (s > 15) ? 4'd15 : 4'(s);
    endfunction

    // Level counts up on each win and sticks at MAX_LEVEL.
    function automatic logic [3:0] sat_level(input logic [3:0] lvl);
        return (int'(lvl) >= MAX_LEVEL) ? 4'(MAX_LEVEL) : lvl + 4'd1;
    endfunction

    function automatic logic [9:0] init_y(input int lane);
        return 10'(INIT_Y0 + lane * INIT_STEP);
    endfunction

    // One motion step; limit tests are done at 11 bits before truncating.
    function automatic lane_t step_lane(input logic [9:0] y, input logic dir,
                                        input logic [3:0] spd);
        lane_t       r;
        logic [10:0] y11;
        logic [10:0] s11;
        logic [10:0] t;
        y11   = {1'b0, y};
        s11   = {7'd0, spd};
        r.y   = y;
        r.dir = dir;
        if (dir) begin
            t = y11 + s11;
            if (t >= LIM) begin
                r.y   = (WRAP_MODE != 0) ? YMIN[9:0] : LIM[9:0];
                r.dir = (WRAP_MODE != 0);
            end else begin
                r.y = t[9:0];
            end
        end else begin
            if (y11 <= YMIN + s11) begin
                r.y   = (WRAP_MODE != 0) ? LIM[9:0] : YMIN[9:0];
                r.dir = (WRAP_MODE == 0);
            end else begin
                t   = y11 - s11;
                r.y = t[9:0];
            end
        end
        return r;
    endfunction

    // Half-open box overlap: touching edges do not count as a hit.
    function automatic logic hit_lane(input int lane, input logic [9:0] cy,
                                      input logic [9:0] fx, input logic [9:0] fy);
        logic [11:0] cx, cyw, fxw, fyw;
        cx  = 12'(LANE_X0 + lane * LANE_PITCH);
        cyw = {2'b00, cy};
        fxw = {2'b00, fx};
        fyw = {2'b00, fy};
        return (fxw < cx + 12'(CROC_W)) && (cx < fxw + 12'(FROG_W)) &&
               (fyw < cyw + 12'(CROC_H)) && (cyw < fyw + 12'(FROG_H));
    endfunction

    assign tick_w = bus.enable && !reset && (presc_q == PW'(TICK_DIV - 1));

    // Prescaler counts enabled cycles and wraps once per motion tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q <= '0;
        end else if (bus.enable) begin
            presc_q <= (presc_q == PW'(TICK_DIV - 1)) ? '0 : presc_q + PW'(1);
        end
    end

    // Raw overlap of the frog against every lane box.
    always_comb begin
        hit_any = 1'b0;
        for (int i = 0; i < N_LANES; i++) begin
            hit_any = hit_any | hit_lane(i, y_q[i], bus.frog_x, bus.frog_y);
        end
    end

    // Candidate next position of every lane for a motion tick.
    always_comb begin
        for (int i = 0; i < N_LANES; i++) begin
            nxt[i] = step_lane(y_q[i], dir_q[i], sat_speed(i, level_q));
        end
    end

    // Next state: death beats win, win's reload beats a tick's motion.
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        level_d   = level_q;
        die_d     = 1'b0;
        do_reload = 1'b0;
        do_move   = 1'b0;
        case (state_q)
            RUN: begin
                if (bus.enable && hit_any) begin
                    state_d = HOLD;
                    hold_d  = 8'(HOLD_TICKS);
                    die_d   = 1'b1;
                end else if (bus.win) begin
                    level_d   = sat_level(level_q);
                    do_reload = 1'b1;
                end else if (tick_w) begin
                    do_move = 1'b1;
                end
            end
            HOLD: begin
                if (tick_w) begin
                    if (hold_q <= 8'd1) begin
                        state_d = RUN;
                        hold_d  = 8'd0;
                    end else begin
                        hold_d = hold_q - 8'd1;
                    end
                end
            end
            default: state_d = RUN;
        endcase
    end

    // Control registers; reset drops any pending die pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            hold_q  <= 8'd0;
            level_q <= 4'd0;
            die_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            level_q <= level_d;
            die_q   <= die_d;
        end
    end

    // Lane positions: reload on reset or win, otherwise step on a RUN tick.
    always_ff @(posedge clk) begin
        if (reset || do_reload) begin
            for (int i = 0; i < N_LANES; i++) begin
                y_q[i]   <= init_y(i);
                dir_q[i] <= ((i % 2) == 0);
            end
        end else if (do_move) begin
            for (int i = 0; i < N_LANES; i++) begin
                y_q[i]   <= nxt[i].y;
                dir_q[i] <= nxt[i].dir;
            end
        end
    end

    // Pack lane positions onto the output bus.
    always_comb begin
        bus.croc_y = '0;
        for (int i = 0; i < N_LANES; i++) begin
            bus.croc_y[10*i +: 10] = y_q[i];
        end
    end

    assign bus.croc_dir = dir_q;
    assign bus.level    = level_q;
    assign bus.tick     = tick_w;
    assign bus.die      = die_q;
endmodule
